// File: rtl/dm_resp.sv
// Multicycle data-memory responder: accepts one load/store at a time, inserts
// WAIT_CYC wait states, then returns a one-cycle ready pulse with data or error.
module dm_resp #(
    parameter int ADDR_W   = 12,
    parameter int WAIT_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              wr,
    input  logic              bmode,
    input  logic              sext,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              ready,
    output logic [31:0]       rdata,
    output logic              err
);

    localparam int DEPTH = 1 << (ADDR_W - 2);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t              state;
    logic [3:0]          cnt;
    logic                l_wr;
    logic                l_bmode;
    logic                l_sext;
    logic [ADDR_W-1:0]   l_addr;
    logic [31:0]         l_wdata;

    logic [31:0]         mem [DEPTH];

    logic [ADDR_W-3:0]   idx;
    logic [1:0]          lane;
    logic [31:0]         word;
    logic [7:0]          lane_byte;
    logic [31:0]         load_val;
    logic [31:0]         store_val;
    logic                access;

    assign idx    = l_addr[ADDR_W-1:2];
    assign lane   = l_addr[1:0];
    assign word   = mem[idx];
    assign access = (state == S_WAIT) && (cnt == 4'd0);

    always_comb begin
        lane_byte = word[7:0];
        store_val = word;
        case (lane)
            2'd0: begin lane_byte = word[7:0];   store_val[7:0]   = l_wdata[7:0]; end
            2'd1: begin lane_byte = word[15:8];  store_val[15:8]  = l_wdata[7:0]; end
            2'd2: begin lane_byte = word[23:16]; store_val[23:16] = l_wdata[7:0]; end
            default: begin lane_byte = word[31:24]; store_val[31:24] = l_wdata[7:0]; end
        endcase
        if (!l_bmode)
            store_val = l_wdata;
        if (l_bmode)
            load_val = {{24{l_sext & lane_byte[7]}}, lane_byte};
        else
            load_val = word;
    end

    // The array has no reset; a reset during WAIT leaves state IDLE, so no write fires.
    always_ff @(posedge clk) begin
        if (access && l_wr)
            mem[idx] <= store_val;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= 4'd0;
            l_wr    <= 1'b0;
            l_bmode <= 1'b0;
            l_sext  <= 1'b0;
            l_addr  <= '0;
            l_wdata <= 32'd0;
            busy    <= 1'b0;
            ready   <= 1'b0;
            err     <= 1'b0;
            rdata   <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req) begin
                        l_wr    <= wr;
                        l_bmode <= bmode;
                        l_sext  <= sext;
                        l_addr  <= addr;
                        l_wdata <= wdata;
                        busy    <= 1'b1;
                        // Misaligned word access skips the array and completes at once.
                        if (!bmode && (addr[1:0] != 2'b00)) begin
                            state <= S_DONE;
                            ready <= 1'b1;
                            err   <= 1'b1;
                            rdata <= 32'd0;
                        end else begin
                            state <= S_WAIT;
                            cnt   <= 4'(WAIT_CYC);
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state <= S_DONE;
                        ready <= 1'b1;
                        err   <= 1'b0;
                        if (!l_wr)
                            rdata <= load_val;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    ready <= 1'b0;
                    err   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dm_resp.sv
// Directed table-driven bench for dm_resp: timing, data paths, misalignment,
// reset during wait states, and back-to-back requests with zero wait states.
module tb_dm_resp;

    logic        clk;
    logic        rst;
    logic        req, wr, bmode, sext;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        busy, ready, err;
    logic [31:0] rdata;

    logic        req0;
    logic        busy0, ready0, err0;
    logic [31:0] rdata0;

    int errors = 0;
    int checks = 0;

    dm_resp #(.ADDR_W(12), .WAIT_CYC(2)) dut (
        .clk(clk), .rst(rst), .req(req), .wr(wr), .bmode(bmode), .sext(sext),
        .addr(addr), .wdata(wdata), .busy(busy), .ready(ready), .rdata(rdata), .err(err)
    );

    dm_resp #(.ADDR_W(12), .WAIT_CYC(0)) dut0 (
        .clk(clk), .rst(rst), .req(req0), .wr(1'b0), .bmode(1'b0), .sext(1'b0),
        .addr(12'h040), .wdata(32'd0), .busy(busy0), .ready(ready0), .rdata(rdata0), .err(err0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic        bmode;
        logic        sext;
        logic [11:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[16];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    // Issues one request to the main DUT and waits (bounded) for its ready pulse.
    task automatic applyStimulus(input logic t_wr, input logic t_bmode, input logic t_sext,
                                 input logic [11:0] t_addr, input logic [31:0] t_wdata,
                                 output int lat, output logic [31:0] rd, output logic er);
        @(negedge clk);
        wr = t_wr; bmode = t_bmode; sext = t_sext; addr = t_addr; wdata = t_wdata;
        req = 1'b1;
        @(posedge clk);
        #1 req = 1'b0;
        lat = 0; rd = 32'd0; er = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (ready) begin
                lat = i; rd = rdata; er = err;
                break;
            end
        end
    endtask

    initial begin
        int          lat;
        logic [31:0] rd;
        logic        er;
        int          pulses;

        vecs[0]  = '{1'b1, 1'b0, 1'b0, 12'h010, 32'hDEADBEEF, 4, 32'h00000000, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 12'h010, 32'h00000000, 4, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 1'b1, 12'h012, 32'hFFFFFF5A, 4, 32'hDEADBEEF, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 12'h010, 32'h00000000, 4, 32'hDE5ABEEF, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 12'h013, 32'h00000000, 4, 32'hFFFFFFDE, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 12'h013, 32'h00000000, 4, 32'h000000DE, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 12'h012, 32'h00000000, 4, 32'h0000005A, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 12'h020, 32'hCAFEF00D, 4, 32'h0000005A, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 12'h021, 32'h00000000, 1, 32'h00000000, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 12'h020, 32'h00000000, 4, 32'hCAFEF00D, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 12'hFFC, 32'h12345678, 4, 32'hCAFEF00D, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 1'b1, 12'hFFF, 32'h00000000, 4, 32'h00000012, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 12'h022, 32'h00000000, 1, 32'h00000000, 1'b1};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 12'hFFC, 32'h00000000, 4, 32'h12345678, 1'b0};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 12'h010, 32'h00000000, 4, 32'h000000EF, 1'b0};
        vecs[15] = '{1'b0, 1'b1, 1'b1, 12'h010, 32'h00000000, 4, 32'hFFFFFFEF, 1'b0};

        req = 1'b0; wr = 1'b0; bmode = 1'b0; sext = 1'b0; addr = '0; wdata = '0;
        req0 = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_busy",  {31'd0, busy},  32'd0);
        checkOutput("reset_ready", {31'd0, ready}, 32'd0);
        checkOutput("reset_err",   {31'd0, err},   32'd0);
        checkOutput("reset_rdata", rdata,          32'd0);
        rst = 1'b0;

        for (int v = 0; v < 16; v++) begin
            applyStimulus(vecs[v].wr, vecs[v].bmode, vecs[v].sext, vecs[v].addr, vecs[v].wdata, lat, rd, er);
            checkOutput($sformatf("v%0d_latency", v), 32'(lat), 32'(vecs[v].lat));
            checkOutput($sformatf("v%0d_rdata", v), rd, vecs[v].exp_rdata);
            checkOutput($sformatf("v%0d_err", v), {31'd0, er}, {31'd0, vecs[v].exp_err});
            @(negedge clk);
            checkOutput($sformatf("v%0d_ready_pulse", v), {31'd0, ready}, 32'd0);
        end

        // Reset two cycles into a store of 0 to 0xFFC: the write must be abandoned.
        @(negedge clk);
        wr = 1'b1; bmode = 1'b0; sext = 1'b0; addr = 12'hFFC; wdata = 32'd0;
        req = 1'b1;
        @(posedge clk);
        #1 req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("wait_busy_before_rst", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("rst_busy_drop", {31'd0, busy}, 32'd0);
        checkOutput("rst_rdata_clear", rdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ready) pulses++;
        end
        checkOutput("rst_no_ready", 32'(pulses), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 12'hFFC, 32'd0, lat, rd, er);
        checkOutput("rst_reload_latency", 32'(lat), 32'd4);
        checkOutput("rst_reload_rdata", rd, 32'h12345678);

        // Zero wait states with req held high: ready every 3 cycles, busy low one cycle.
        @(negedge clk);
        req0 = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checkOutput($sformatf("w0_ready_%0d", k), {31'd0, ready0}, {31'd0, (k % 3) == 1});
            checkOutput($sformatf("w0_busy_%0d", k),  {31'd0, busy0},  {31'd0, (k % 3) != 2});
        end
        req0 = 1'b0;
        checkOutput("w0_err", {31'd0, err0}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dm_resp.md
Name: dm_resp

Overview:
- Multicycle data-memory responder: the target side of the CPU's load/store interface.
- Accepts one request at a time from the datapath and inserts a programmable number of wait states.
- Performs word or byte access on an internal 1024x32 array, with sign or zero extension for byte loads.
- Returns a one-cycle `ready` pulse carrying the read data or an alignment error.
- Replaces the single-cycle data memory so that the control FSM can stall on memory.

Parameters:
- `ADDR_W`, 12, byte-address width; array depth is 2^(ADDR_W-2) words.
- `WAIT_CYC`, 2, wait states inserted before the access; legal range 0..15.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req` in 1: request strobe; sampled only when `busy`=0.
- `wr` in 1: 1 = store, 0 = load; latched with `req`.
- `bmode` in 1: 1 = byte access, 0 = word access; latched with `req`.
- `sext` in 1: byte loads only; 1 = sign-extend (lb), 0 = zero-extend (lbu); latched with `req`.
- `addr` in `ADDR_W`: byte address; latched with `req`.
- `wdata` in 32: store data; for byte stores, `wdata[7:0]` is used; latched with `req`.
- `busy` out 1: high whenever state != IDLE.
- `ready` out 1: one-cycle completion pulse.
- `rdata` out 32: load result; valid while `ready`=1 for a load.
- `err` out 1: misaligned word access; valid only with `ready`.

Behaviour:
- Reset (async, `rst`=1):
  - State forced to IDLE; the wait counter and the latched request are cleared.
  - `busy`=0, `ready`=0, `err`=0, `rdata`=0.
  - Memory array contents are NOT reset.
- States: IDLE, WAIT, DONE.
- IDLE:
  - If `req`=1 at a rising edge, latch `wr`, `bmode`, `sext`, `addr`, `wdata`.
  - If `bmode`=0 and `addr[1:0]`!=0: go to DONE with the error flag set; no array access is performed.
  - Otherwise go to WAIT with counter = `WAIT_CYC`.
  - If `req`=0, stay in IDLE.
- WAIT:
  - If counter != 0: decrement and stay in WAIT.
  - If counter == 0: perform the access on this edge and go to DONE.
- DONE:
  - `ready`=1 and `err`=flag for exactly this one cycle.
  - Next edge: go to IDLE and clear the flag.
  - `req` is ignored in this state; a new request can be accepted on the cycle after DONE.
- Latency:
  - `req` sampled at edge N; `ready` is high in the cycle following edge N+`WAIT_CYC`+1.
  - That is `WAIT_CYC`+2 cycles; 4 cycles with the default.
  - A misaligned request gives `ready` in the cycle following edge N (1 cycle).
- Indexing:
  - Word index = `addr[ADDR_W-1:2]`; byte lane = `addr[1:0]`.
  - Little-endian lanes: lane 0 = bits [7:0], lane 3 = bits [31:24].
- Word load: `rdata` = array word.
- Byte load:
  - `rdata[7:0]` = selected lane.
  - `rdata[31:8]` = replicated lane bit 7 if `sext`=1, else 0.
- Word store: the whole word is written.
- Byte store: only the selected lane is written from `wdata[7:0]`; the other three lanes are unchanged.
  - `sext` has no effect on stores.
- `rdata` update rule:
  - Updated only on a completed load; holds its value otherwise, including across stores.
  - Forced to 0 on an error completion.
- Boundaries:
  - Highest address 0xFFF: word index 1023, legal; no wrap or overflow is possible.
  - `WAIT_CYC`=0: WAIT lasts one cycle and the access happens on its exit edge.
  - `rst` asserted during WAIT before the access edge: no write occurs and no `ready` is produced.
  - `req` held high continuously: one request per IDLE visit, i.e. back-to-back transactions spaced by `busy`.

Test Plan:
- Reset, then a word store of 0xDEADBEEF to address 0x010, then a word load from 0x010:
  - Each transaction gives `ready` exactly 4 cycles after `req`.
  - The load returns `rdata`=0xDEADBEEF and `err`=0.
- After the word above, byte store 0x5A to 0x012, then word load 0x010 -> `rdata`=0xDE5ABEEF.
- Byte loads from 0x013:
  - `sext`=1 -> 0xFFFFFFDE.
  - `sext`=0 -> 0x000000DE.
  - Byte load from 0x012 with `sext`=1 -> 0x0000005A.
- Word store to 0x021 (misaligned):
  - `ready` and `err` both high 1 cycle after `req`; `rdata`=0.
  - A subsequent word load from 0x020 returns the prior contents, i.e. no write occurred.
- Store 0x12345678 to 0xFFC, then assert `rst` two cycles after a new store of 0 to 0xFFC:
  - `busy` drops immediately and no `ready` is produced.
  - A reload of 0xFFC returns 0x12345678.
- Rebuild with `WAIT_CYC`=0, hold `req`=1 for 10 cycles with loads:
  - `ready` pulses every 3 cycles, each 2 cycles after acceptance.
  - `busy` is low exactly one cycle between transactions.
